// File: rtl/aes_ser_pkg.sv
// aes_ser_pkg: shared constants and types for the AES block serializer
package aes_ser_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W = 8;
  typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;
  typedef logic [AES_BYTE_W-1:0] aes_byte_t;
endpackage

// File: rtl/aes_block_serializer.sv
// aes_block_serializer: parallel AES block to byte stream, MSB byte first; AES_SER_LAST_EN adds out_last
module aes_block_serializer
  import aes_ser_pkg::*;
#(
  parameter int NUM_BYTES = AES_BLOCK_BYTES,
  parameter int BYTE_W = AES_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_BYTES*BYTE_W-1:0] in_block,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BYTE_W-1:0]           out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef AES_SER_LAST_EN
  output logic                        out_last,
`endif
  output logic                        busy
);
  localparam int CW = $clog2(NUM_BYTES);
  ser_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_BYTES*BYTE_W-1:0] sr;
  logic last, load, adv;
  always_comb begin
    last = cnt == CW'(NUM_BYTES - 1);
    out_valid = state == SER_SEND;
    busy = out_valid;
    out_byte = sr[NUM_BYTES*BYTE_W-1 -: BYTE_W];
    in_ready = out_valid ? last && out_ready : 1'b1;
    load = in_valid && in_ready;
    adv = out_valid && out_ready;
    state_n = load ? SER_SEND : (adv && last) ? SER_IDLE : state;
  end
`ifdef AES_SER_LAST_EN
  assign out_last = out_valid && last;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SER_IDLE;
      cnt <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        sr <= in_block;
        cnt <= '0;
      end else if (adv) begin
        sr <= sr << BYTE_W;
        cnt <= last ? cnt : cnt + CW'(1);
      end
    end
  end
endmodule
